// File: rtl/memory_access_if.sv
// Data-memory bus between the MEM stage (master) and the memory system (slave).
// One outstanding request; req is held with stable addr/be/wdata until gnt.
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/gnt/rvalid bus, with
// registered results toward writeback, alignment/legality faults and a bus timeout.
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter type         wb_source_type = logic [1:0]
) (
  input  logic                 clk_i,
  input  logic                 n_rst,
  input  logic                 valid_i,
  input  logic [4:0]           rd_i,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          rs2_data_i,
  input  logic [31:0]          pc_4_i,
  input  logic                 memread_en_i,
  input  logic                 memwrite_en_i,
  input  logic [2:0]           mem_funct3_i,
  input  logic                 wb_en_i,
  input  wb_source_type        wb_src_i,
  output logic                 stall_o,
  output logic                 valid_o,
  output logic [4:0]           rd_o,
  output logic [31:0]          alu_result_o,
  output logic [31:0]          pc_4_o,
  output logic [31:0]          mem_rdata_o,
  output logic                 wb_en_o,
  output wb_source_type        wb_src_o,
  output logic                 fault_o,
  memory_access_if.master      dmem
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e          state_q, state_d;
  logic [4:0]      rd_q;
  logic [31:0]     addr_q, wdata_q, pc4_q;
  logic [2:0]      f3_q;
  logic            we_q, wb_en_q;
  wb_source_type   wb_src_q;
  logic [CntW-1:0] cnt_q;

  logic        mem_op, misaligned, illegal, accept;
  logic        pass, ifault, start, timeout;
  logic        store_done, load_done, abort;
  logic        res_valid, res_fault, from_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;

  assign mem_op     = memread_en_i | memwrite_en_i;
  assign misaligned = ((mem_funct3_i[1:0] == 2'd1) && alu_result_i[0]) ||
                      ((mem_funct3_i[1:0] == 2'd2) && (alu_result_i[1:0] != 2'b00));
  assign illegal    = (mem_funct3_i inside {3'd3, 3'd6, 3'd7}) ||
                      (memwrite_en_i && (mem_funct3_i > 3'd2)) ||
                      (memread_en_i && memwrite_en_i);

  assign accept = (state_q == StIdle) && valid_i;
  assign pass   = accept && !mem_op;
  assign ifault = accept && mem_op && (misaligned || illegal);
  assign start  = accept && mem_op && !(misaligned || illegal);

  // Counter value c means c+1 cycles have been spent in REQ/RESP.
  assign timeout    = (TIMEOUT_CYCLES != 0) && (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));
  assign store_done = (state_q == StReq) && dmem.gnt && we_q;
  assign load_done  = (state_q == StResp) && dmem.rvalid;
  assign abort      = timeout && (((state_q == StReq) && !dmem.gnt) ||
                                  ((state_q == StResp) && !dmem.rvalid));

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (dmem.gnt) state_d = we_q ? StIdle : StResp;
               else if (timeout) state_d = StIdle;
      StResp:  if (dmem.rvalid || timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_o    = (state_q != StIdle);
    dmem.req   = (state_q == StReq);
    dmem.we    = 1'b0;
    dmem.addr  = '0;
    dmem.be    = '0;
    dmem.wdata = '0;
    if (state_q == StReq) begin
      dmem.we   = we_q;
      dmem.addr = {addr_q[31:2], 2'b00};
      case (f3_q[1:0])
        2'd0: begin
          dmem.be    = 4'b0001 << addr_q[1:0];
          dmem.wdata = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          dmem.be    = addr_q[1] ? 4'b1100 : 4'b0011;
          dmem.wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          dmem.be    = 4'b1111;
          dmem.wdata = wdata_q;
        end
      endcase
      if (!we_q) dmem.wdata = '0;
    end
  end

  always_comb begin
    lane_b = dmem.rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = dmem.rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'd0:    ext = {{24{lane_b[7]}}, lane_b};
      3'd4:    ext = {24'b0, lane_b};
      3'd1:    ext = {{16{lane_h[15]}}, lane_h};
      3'd5:    ext = {16'b0, lane_h};
      default: ext = dmem.rdata;
    endcase
  end

  assign res_valid = pass | ifault | store_done | load_done | abort;
  assign res_fault = ifault | abort;
  assign from_in   = pass | ifault;

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      rd_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pc4_q    <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      wb_en_q  <= 1'b0;
      wb_src_q <= '0;
    end else if (start) begin
      rd_q     <= rd_i;
      addr_q   <= alu_result_i;
      wdata_q  <= rs2_data_i;
      pc4_q    <= pc_4_i;
      f3_q     <= mem_funct3_i;
      we_q     <= memwrite_en_i;
      wb_en_q  <= wb_en_i;
      wb_src_q <= wb_src_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if ((state_q != StIdle) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Non-memory and faulting ops take fields straight from the inputs; bus ops from latches.
  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      valid_o      <= 1'b0;
      fault_o      <= 1'b0;
      rd_o         <= '0;
      alu_result_o <= '0;
      pc_4_o       <= '0;
      mem_rdata_o  <= '0;
      wb_en_o      <= 1'b0;
      wb_src_o     <= '0;
    end else begin
      valid_o <= res_valid;
      fault_o <= res_fault;
      if (res_valid) begin
        rd_o         <= from_in ? rd_i : rd_q;
        alu_result_o <= from_in ? alu_result_i : addr_q;
        pc_4_o       <= from_in ? pc_4_i : pc4_q;
        wb_src_o     <= from_in ? wb_src_i : wb_src_q;
        wb_en_o      <= !res_fault && (from_in ? wb_en_i : wb_en_q);
        mem_rdata_o  <= load_done ? ext : '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: stimulus pushes expected writeback results and bus
// requests; monitor and memory-responder processes pop and compare as the DUT presents them.
module tb_memory_access;

  typedef struct {
    logic        fault;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        wb_en;
    logic [1:0]  wb_src;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk_i = 1'b0;
  logic        n_rst;
  logic        valid_i, memread_en_i, memwrite_en_i, wb_en_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i, rs2_data_i, pc_4_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  wb_src_i;
  logic        stall_o, valid_o, wb_en_o, fault_o;
  logic [4:0]  rd_o;
  logic [31:0] alu_result_o, pc_4_o, mem_rdata_o;
  logic [1:0]  wb_src_o;

  memory_access_if dmem ();

  memory_access #(
    .TIMEOUT_CYCLES (8),
    .wb_source_type (logic [1:0])
  ) dut (
    .clk_i         (clk_i),
    .n_rst         (n_rst),
    .valid_i       (valid_i),
    .rd_i          (rd_i),
    .alu_result_i  (alu_result_i),
    .rs2_data_i    (rs2_data_i),
    .pc_4_i        (pc_4_i),
    .memread_en_i  (memread_en_i),
    .memwrite_en_i (memwrite_en_i),
    .mem_funct3_i  (mem_funct3_i),
    .wb_en_i       (wb_en_i),
    .wb_src_i      (wb_src_i),
    .stall_o       (stall_o),
    .valid_o       (valid_o),
    .rd_o          (rd_o),
    .alu_result_o  (alu_result_o),
    .pc_4_o        (pc_4_o),
    .mem_rdata_o   (mem_rdata_o),
    .wb_en_o       (wb_en_o),
    .wb_src_o      (wb_src_o),
    .fault_o       (fault_o),
    .dmem          (dmem)
  );

  always #5 clk_i = ~clk_i;

  res_t        exp_q[$];
  bus_t        bus_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0, req_cycles = 0, stall_cycles = 0;
  int          valid_cyc = -1, stall_rise_cyc = -1;
  logic        stall_prev = 1'b0;
  int          gnt_wait = 0, rv_wait = 0, wait_cnt = 0, rv_cnt = 0;
  bit          rv_never = 1'b0, rv_pending = 1'b0;
  logic [31:0] mem_rdata = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Writeback monitor.
  initial begin
    res_t e;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (dmem.req) req_cycles++;
      if (stall_o) stall_cycles++;
      if (stall_o && !stall_prev) stall_rise_cyc = cyc;
      stall_prev = stall_o;
      if (valid_o) begin
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: got valid_o=1 rd_o=%0d expected no result", rd_o);
        end else begin
          e = exp_q.pop_front();
          chk("fault_o", {31'b0, fault_o}, {31'b0, e.fault});
          chk("rd_o", {27'b0, rd_o}, {27'b0, e.rd});
          chk("alu_result_o", alu_result_o, e.alu);
          chk("pc_4_o", pc_4_o, e.pc4);
          chk("mem_rdata_o", mem_rdata_o, e.rdata);
          chk("wb_en_o", {31'b0, wb_en_o}, {31'b0, e.wb_en});
          chk("wb_src_o", {30'b0, wb_src_o}, {30'b0, e.wb_src});
        end
      end
    end
  end

  // Memory responder: grants after gnt_wait cycles, returns read data rv_wait cycles later.
  initial begin
    bus_t b;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = '0;
    forever begin
      @(negedge clk_i);
      dmem.gnt    = 1'b0;
      dmem.rvalid = 1'b0;
      if (rv_pending) begin
        if (!rv_never) begin
          if (rv_cnt >= rv_wait) begin
            dmem.rvalid = 1'b1;
            dmem.rdata  = mem_rdata;
            rv_pending  = 1'b0;
          end else begin
            rv_cnt++;
          end
        end
      end else if (dmem.req) begin
        if (wait_cnt >= gnt_wait) begin
          dmem.gnt = 1'b1;
          wait_cnt = 0;
          if (bus_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_req: got req addr=0x%08h expected no request", dmem.addr);
          end else begin
            b = bus_q.pop_front();
            chk("bus_we", {31'b0, dmem.we}, {31'b0, b.we});
            chk("bus_addr", dmem.addr, b.addr);
            chk("bus_be", {28'b0, dmem.be}, {28'b0, b.be});
            chk("bus_wdata", dmem.wdata, b.wdata);
          end
          if (!dmem.we) begin
            rv_pending = 1'b1;
            rv_cnt     = 0;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic issue(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [31:0] pc4, input logic rd_en, input logic wr_en,
                       input logic [2:0] f3, input logic wb_en, input logic [1:0] wb_src,
                       input logic exp_fault, input logic [31:0] exp_rdata);
    res_t e;
    int   g = 0;
    @(negedge clk_i);
    while (stall_o && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    if (stall_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_wait: got stall_o=1 after 100 cycles expected 0");
    end
    e.fault  = exp_fault;
    e.rd     = rd;
    e.alu    = alu;
    e.pc4    = pc4;
    e.rdata  = exp_rdata;
    e.wb_en  = wb_en && !exp_fault;
    e.wb_src = wb_src;
    exp_q.push_back(e);
    rd_i          = rd;
    alu_result_i  = alu;
    rs2_data_i    = rs2;
    pc_4_i        = pc4;
    memread_en_i  = rd_en;
    memwrite_en_i = wr_en;
    mem_funct3_i  = f3;
    wb_en_i       = wb_en;
    wb_src_i      = wb_src;
    valid_i       = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i       = 1'b0;
    memread_en_i  = 1'b0;
    memwrite_en_i = 1'b0;
  endtask

  task automatic settle();
    int g = 0;
    while ((stall_o || exp_q.size() != 0) && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL settle: got %0d results outstanding expected 0", exp_q.size());
    end
    @(negedge clk_i);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    bus_t b;
    b.we    = we;
    b.addr  = addr;
    b.be    = be;
    b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0, vc;
    int g;
    n_rst = 1'b0;
    {valid_i, memread_en_i, memwrite_en_i, wb_en_i} = '0;
    rd_i = '0; alu_result_i = '0; rs2_data_i = '0; pc_4_i = '0;
    mem_funct3_i = '0; wb_src_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_req", {31'b0, dmem.req}, 32'd0);
    chk("rst_fault", {31'b0, fault_o}, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    n_rst = 1'b1;

    // Pass-through ALU op and JAL-style pc+4 forwarding.
    r0 = req_cycles;
    issue(5'd5, 32'h1234, 32'h0, 32'h104, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 32'h0);
    issue(5'd1, 32'h0, 32'h0, 32'h108, 1'b0, 1'b0, 3'd0, 1'b1, 2'd2, 1'b0, 32'h0);
    settle();
    chk("alu_no_req", req_cycles - r0, 32'd0);

    // SB with two wait cycles before gnt.
    gnt_wait = 2;
    push_bus(1'b1, 32'h1000, 4'b1000, 32'hABABABAB);
    r0 = req_cycles;
    s0 = stall_cycles;
    issue(5'd0, 32'h1003, 32'hAB, 32'h200, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b0, 32'h0);
    settle();
    chk("sb_req_cycles", req_cycles - r0, 32'd3);
    chk("sb_stall_cycles", stall_cycles - s0, 32'd3);
    gnt_wait = 0;

    push_bus(1'b1, 32'h3000, 4'b1100, 32'h56785678);
    issue(5'd0, 32'h3002, 32'h12345678, 32'h204, 1'b0, 1'b1, 3'd1, 1'b0, 2'd0, 1'b0, 32'h0);
    push_bus(1'b1, 32'h3004, 4'b1111, 32'hDEADBEEF);
    issue(5'd0, 32'h3004, 32'hDEADBEEF, 32'h208, 1'b0, 1'b1, 3'd2, 1'b0, 2'd0, 1'b0, 32'h0);
    settle();

    // Loads with extraction and extension.
    mem_rdata = 32'h000080FF;
    push_bus(1'b0, 32'h2000, 4'b0010, 32'h0);
    issue(5'd6, 32'h2001, 32'h0, 32'h300, 1'b1, 1'b0, 3'd0, 1'b1, 2'd1, 1'b0, 32'hFFFFFF80);
    push_bus(1'b0, 32'h2000, 4'b0010, 32'h0);
    issue(5'd7, 32'h2001, 32'h0, 32'h304, 1'b1, 1'b0, 3'd4, 1'b1, 2'd1, 1'b0, 32'h00000080);
    push_bus(1'b0, 32'h2000, 4'b1100, 32'h0);
    issue(5'd8, 32'h2002, 32'h0, 32'h308, 1'b1, 1'b0, 3'd5, 1'b1, 2'd1, 1'b0, 32'h00000000);
    push_bus(1'b0, 32'h2000, 4'b0011, 32'h0);
    issue(5'd9, 32'h2000, 32'h0, 32'h30C, 1'b1, 1'b0, 3'd1, 1'b1, 2'd1, 1'b0, 32'hFFFF80FF);
    settle();
    rv_wait = 3;
    gnt_wait = 1;
    mem_rdata = 32'hCAFEF00D;
    push_bus(1'b0, 32'h2004, 4'b1111, 32'h0);
    issue(5'd10, 32'h2004, 32'h0, 32'h310, 1'b1, 1'b0, 3'd2, 1'b1, 2'd1, 1'b0, 32'hCAFEF00D);
    push_bus(1'b0, 32'h2008, 4'b1000, 32'h0);
    issue(5'd11, 32'h200B, 32'h0, 32'h314, 1'b1, 1'b0, 3'd4, 1'b1, 2'd1, 1'b0, 32'h000000CA);
    settle();
    rv_wait = 0;
    gnt_wait = 0;

    // Misaligned and illegal accesses: fault, no bus traffic.
    r0 = req_cycles;
    issue(5'd12, 32'h2002, 32'h0, 32'h400, 1'b1, 1'b0, 3'd2, 1'b1, 2'd1, 1'b1, 32'h0);
    issue(5'd13, 32'h2001, 32'h0, 32'h404, 1'b1, 1'b0, 3'd1, 1'b1, 2'd1, 1'b1, 32'h0);
    issue(5'd14, 32'h2000, 32'h0, 32'h408, 1'b1, 1'b0, 3'd3, 1'b1, 2'd1, 1'b1, 32'h0);
    issue(5'd15, 32'h2000, 32'h0, 32'h40C, 1'b1, 1'b0, 3'd6, 1'b1, 2'd1, 1'b1, 32'h0);
    issue(5'd16, 32'h1000, 32'h55, 32'h410, 1'b0, 1'b1, 3'd4, 1'b1, 2'd0, 1'b1, 32'h0);
    issue(5'd17, 32'h1000, 32'h55, 32'h414, 1'b1, 1'b1, 3'd2, 1'b1, 2'd1, 1'b1, 32'h0);
    issue(5'd18, 32'h1002, 32'h55, 32'h418, 1'b0, 1'b1, 3'd1, 1'b0, 2'd0, 1'b0, 32'h0);
    push_bus(1'b1, 32'h1000, 4'b1100, 32'h00550055);
    settle();
    chk("fault_req_cycles", req_cycles - r0, 32'd1);

    // Timeout: gnt but no rvalid.
    rv_never = 1'b1;
    push_bus(1'b0, 32'h2000, 4'b1111, 32'h0);
    issue(5'd19, 32'h2000, 32'h0, 32'h500, 1'b1, 1'b0, 3'd2, 1'b1, 2'd1, 1'b1, 32'h0);
    settle();
    chk("timeout_latency", valid_cyc - stall_rise_cyc, 32'd8);
    chk("timeout_idle", {31'b0, stall_o}, 32'd0);
    rv_pending = 1'b0;

    // Reset while waiting in RESP, then a stray rvalid.
    push_bus(1'b0, 32'h2000, 4'b1111, 32'h0);
    issue(5'd20, 32'h2000, 32'h0, 32'h600, 1'b1, 1'b0, 3'd2, 1'b1, 2'd1, 1'b0, 32'h0);
    g = 0;
    while (!rv_pending && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    chk("resp_reached", {31'b0, rv_pending}, 32'd1);
    @(negedge clk_i);
    n_rst = 1'b0;
    #1;
    chk("rst2_stall", {31'b0, stall_o}, 32'd0);
    chk("rst2_valid", {31'b0, valid_o}, 32'd0);
    chk("rst2_req", {31'b0, dmem.req}, 32'd0);
    chk("rst2_rd", {27'b0, rd_o}, 32'd0);
    chk("rst2_alu", alu_result_o, 32'd0);
    chk("rst2_pc4", pc_4_o, 32'd0);
    exp_q.delete();
    vc = valid_cyc;
    rv_never = 1'b0;
    rv_pending = 1'b0;
    @(negedge clk_i);
    n_rst = 1'b1;
    rv_cnt = 0;
    rv_pending = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("stray_rvalid_ignored", valid_cyc, vc);
    issue(5'd3, 32'h55, 32'h0, 32'h700, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b0, 32'h0);
    settle();

    chk("results_drained", exp_q.size(), 32'd0);
    chk("bus_drained", bus_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
